// File: rtl/sha1_pkg.sv
// Shared constants and state encoding for the SHA-1 message controller.
// The FIPS 180 initial context is kept here so every user agrees on it.
package sha1_pkg;

  localparam int unsigned SHA1_BLOCK_W  = 512;
  localparam int unsigned SHA1_DIGEST_W = 160;

  localparam logic [31:0] SHA1_H0 = 32'h67452301;
  localparam logic [31:0] SHA1_H1 = 32'hEFCDAB89;
  localparam logic [31:0] SHA1_H2 = 32'h98BADCFE;
  localparam logic [31:0] SHA1_H3 = 32'h10325476;
  localparam logic [31:0] SHA1_H4 = 32'hC3D2E1F0;

  localparam logic [SHA1_DIGEST_W-1:0] SHA1_IV = {SHA1_H0, SHA1_H1, SHA1_H2, SHA1_H3, SHA1_H4};

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StOut   = 2'd3
  } sha1_state_e;

endpackage

// File: rtl/sha1_ctrl_timer.sv
// Start-strobe length counter and, with SHA1_CTRL_TIMEOUT_EN defined,
// a watchdog on the core's done flag.
module sha1_ctrl_timer #(
  parameter int unsigned START_CYCLES = 3,
  parameter int unsigned MAX_WAIT     = 127
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_clr_i,
  input  logic start_en_i,
  input  logic wait_en_i,
  output logic start_done_o,
  output logic timeout_o
);

  localparam int unsigned WdW = ($clog2(MAX_WAIT + 1) > 7) ? $clog2(MAX_WAIT + 1) : 7;

  logic [3:0] start_cnt_q, start_cnt_d;

  always_comb begin
    start_cnt_d = start_cnt_q;
    if (start_clr_i) begin
      start_cnt_d = '0;
    end else if (start_en_i) begin
      start_cnt_d = start_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_cnt_q <= '0;
    end else begin
      start_cnt_q <= start_cnt_d;
    end
  end

  // Fires on the final strobe cycle so the FSM leaves START right after it.
  assign start_done_o = start_en_i && (start_cnt_q == 4'(START_CYCLES - 1));

`ifdef SHA1_CTRL_TIMEOUT_EN
  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (!wait_en_i) begin
      wd_cnt_d = '0;
    end else if (!timeout_o) begin
      wd_cnt_d = wd_cnt_q + WdW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign timeout_o = wait_en_i && (wd_cnt_q == WdW'(MAX_WAIT - 1));
`else
  logic [WdW-1:0] unused_wd;
  assign unused_wd = WdW'(wait_en_i);
  assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/sha1_msg_ctrl.sv
// Message sequencer for sha1_block: IV load, start/done handshake, context chaining
// and digest output. Define SHA1_CTRL_TIMEOUT_EN to enable the done watchdog and err.
module sha1_msg_ctrl
  import sha1_pkg::*;
#(
  parameter int unsigned START_CYCLES = 3,
  parameter int unsigned MAX_WAIT     = 127
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     blk_valid,
  output logic                     blk_ready,
  input  logic [SHA1_BLOCK_W-1:0]  blk_data,
  input  logic                     blk_last,
  output logic                     core_start,
  output logic [SHA1_BLOCK_W-1:0]  core_block,
  output logic [SHA1_DIGEST_W-1:0] core_context_in,
  input  logic                     core_done,
  input  logic [SHA1_DIGEST_W-1:0] core_context_out,
  output logic                     digest_valid,
  input  logic                     digest_ready,
  output logic [SHA1_DIGEST_W-1:0] digest,
  output logic                     busy,
  output logic                     err
);

  sha1_state_e              state_q;
  logic                     start_q;
  logic                     first_q;
  logic                     last_q;
  logic                     wait_armed_q;
  logic                     digest_valid_q;
  logic [SHA1_BLOCK_W-1:0]  block_q;
  logic [SHA1_DIGEST_W-1:0] ctx_q;
  logic [SHA1_DIGEST_W-1:0] digest_q;

  logic start_done;
  logic wd_expire;
  logic blk_done;
  logic abort;

  sha1_ctrl_timer #(
    .START_CYCLES(START_CYCLES),
    .MAX_WAIT    (MAX_WAIT)
  ) u_timer (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_clr_i (state_q == StIdle),
    .start_en_i  (state_q == StStart),
    .wait_en_i   (state_q == StWait),
    .start_done_o(start_done),
    .timeout_o   (wd_expire)
  );

  // The core drops done while started, so done is only trusted from the second WAIT cycle.
  assign blk_done = (state_q == StWait) && wait_armed_q && core_done;
  assign abort    = wd_expire && !blk_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      start_q        <= 1'b0;
      first_q        <= 1'b1;
      last_q         <= 1'b0;
      wait_armed_q   <= 1'b0;
      digest_valid_q <= 1'b0;
      block_q        <= '0;
      ctx_q          <= SHA1_IV;
      digest_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (blk_valid && blk_ready) begin
            block_q <= blk_data;
            last_q  <= blk_last;
            if (first_q) begin
              ctx_q <= SHA1_IV;
            end
            start_q <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (start_done) begin
            start_q      <= 1'b0;
            wait_armed_q <= 1'b0;
            state_q      <= StWait;
          end
        end
        StWait: begin
          wait_armed_q <= 1'b1;
          if (blk_done) begin
            ctx_q <= core_context_out;
            if (last_q) begin
              digest_q       <= core_context_out;
              digest_valid_q <= 1'b1;
              first_q        <= 1'b1;
              state_q        <= StOut;
            end else begin
              first_q <= 1'b0;
              state_q <= StIdle;
            end
          end else if (abort) begin
            // Partial message is dropped; the next block restarts from the IV.
            first_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        StOut: begin
          if (digest_valid_q && digest_ready) begin
            digest_valid_q <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef SHA1_CTRL_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign blk_ready       = (state_q == StIdle);
  assign busy            = (state_q != StIdle);
  assign core_start      = start_q;
  assign core_block      = block_q;
  assign core_context_in = ctx_q;
  assign digest_valid    = digest_valid_q;
  assign digest          = digest_q;

endmodule

// File: tb/tb_sha1_msg_ctrl.sv
// Bench for sha1_msg_ctrl with a behavioural sha1_block stand-in and known-answer vectors.
// Build with +define+SHA1_CTRL_TIMEOUT_EN to exercise the watchdog.
module tb_sha1_msg_ctrl;

  localparam int unsigned StartCycles = 3;
  localparam int unsigned MaxWait     = 127;
  localparam logic [159:0] Iv = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [159:0] DigEmpty = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] DigAbc   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DigTwo   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  typedef struct packed {
    logic [511:0] b0;
    logic [511:0] b1;
    logic [1:0]   nblk;
    logic [159:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_last = 1'b0;
  logic         core_start;
  logic [511:0] core_block;
  logic [159:0] core_context_in;
  logic         core_done = 1'b0;
  logic [159:0] core_context_out = '0;
  logic         digest_valid;
  logic         digest_ready = 1'b0;
  logic [159:0] digest;
  logic         busy;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [511:0] msg[3];
  logic [159:0] exp_ctx[$];

  always #5 clk = ~clk;

  sha1_msg_ctrl #(
    .START_CYCLES(StartCycles),
    .MAX_WAIT    (MaxWait)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .blk_valid       (blk_valid),
    .blk_ready       (blk_ready),
    .blk_data        (blk_data),
    .blk_last        (blk_last),
    .core_start      (core_start),
    .core_block      (core_block),
    .core_context_in (core_context_in),
    .core_done       (core_done),
    .core_context_out(core_context_out),
    .digest_valid    (digest_valid),
    .digest_ready    (digest_ready),
    .digest          (digest),
    .busy            (busy),
    .err             (err)
  );

  function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w[80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, b, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      if (i < 20) begin
        f = (b & c) | (~b & d); k = 32'h5A827999;
      end else if (i < 40) begin
        f = b ^ c ^ d; k = 32'h6ED9EBA1;
      end else if (i < 60) begin
        f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC;
      end else begin
        f = b ^ c ^ d; k = 32'hCA62C1D6;
      end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  function automatic logic [159:0] ref_digest(input int nb);
    logic [159:0] h = Iv;
    for (int i = 0; i < nb; i++) h = sha1_compress(h, msg[i]);
    return h;
  endfunction

  // Behavioural sha1_block: clears done while started, finishes after a random latency.
  int           lat = 0;
  logic         hang = 1'b0;
  logic [511:0] cblk = '0;
  logic [159:0] cctx = '0;

  always @(posedge clk) begin
    if (core_start) begin
      core_done <= 1'b0;
      lat       <= $urandom_range(12, 1);
      cblk      <= core_block;
      cctx      <= core_context_in;
    end else if (lat > 0 && !hang) begin
      lat <= lat - 1;
      if (lat == 1) begin
        core_done        <= 1'b1;
        core_context_out <= sha1_compress(cctx, cblk);
      end
    end
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Strobe width and chaining context checked on every block the DUT starts.
  initial begin : mon
    int   width = 0;
    logic prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1 && !prev) begin
        if (exp_ctx.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_start: got start, expected none");
        end else begin
          check("ctx_in", core_context_in, exp_ctx.pop_front());
        end
      end
      if (core_start === 1'b1) begin
        width++;
      end else if (width != 0) begin
        check("start_width", 160'(width), 160'(StartCycles));
        width = 0;
      end
      prev = (core_start === 1'b1);
    end
  end

  task automatic send_block(input logic [511:0] b, input logic l);
    int n = 0;
    blk_valid = 1'b1; blk_data = b; blk_last = l;
    while (!blk_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!blk_ready) bound_fail("blk_ready_wait");
    @(negedge clk);
    blk_valid = 1'b0; blk_data = '0; blk_last = 1'b0;
  endtask

  task automatic wait_start(input logic lvl, input string name);
    int n = 0;
    while (core_start !== lvl && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (core_start !== lvl) bound_fail(name);
  endtask

  task automatic get_digest(input logic [159:0] exp, input int hold, input string name);
    int n = 0;
    int bad = 0;
    while (!digest_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!digest_valid) begin
      bound_fail(name);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      if (!digest_valid || blk_ready || digest !== exp) bad++;
      @(negedge clk);
    end
    if (hold > 0) check({name, "_hold"}, 160'(bad), 160'(0));
    check(name, digest, exp);
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    check({name, "_consumed"}, 160'(digest_valid), 160'(0));
  endtask

  task automatic run_msg(input int nb, input logic [159:0] exp, input int hold, input string name);
    logic [159:0] h = Iv;
    for (int i = 0; i < nb; i++) begin
      exp_ctx.push_back(h);
      repeat ($urandom_range(2, 0)) @(negedge clk);
      send_block(msg[i], (i == nb - 1));
      h = sha1_compress(h, msg[i]);
    end
    get_digest(exp, hold, name);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : main
    vec_t         vecs[3];
    logic [447:0] two_txt;
    logic [511:0] blk_empty, blk_abc, blk_two0, blk_two1;
    int           bad;

    two_txt   = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    blk_empty = {8'h80, 504'h0};
    blk_abc   = {24'h616263, 8'h80, 416'h0, 64'd24};
    blk_two0  = {two_txt, 8'h80, 56'h0};
    blk_two1  = {448'h0, 64'd448};
    vecs[0] = '{b0: blk_empty, b1: '0, nblk: 2'd1, exp: DigEmpty};
    vecs[1] = '{b0: blk_abc, b1: '0, nblk: 2'd1, exp: DigAbc};
    vecs[2] = '{b0: blk_two0, b1: blk_two1, nblk: 2'd2, exp: DigTwo};

    repeat (3) @(negedge clk);
    check("rst_blk_ready", 160'(blk_ready), 160'(1));
    check("rst_core_start", 160'(core_start), 160'(0));
    check("rst_core_block", core_block[159:0] | core_block[511:352], 160'(0));
    check("rst_ctx_in", core_context_in, Iv);
    check("rst_digest_valid", 160'(digest_valid), 160'(0));
    check("rst_digest", digest, 160'(0));
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_err", 160'(err), 160'(0));
    rst = 1'b0;
    @(negedge clk);

    // Known-answer table; hold time varies per vector.
    for (int i = 0; i < 3; i++) begin
      msg[0] = vecs[i].b0;
      msg[1] = vecs[i].b1;
      run_msg(int'(vecs[i].nblk), vecs[i].exp, i, $sformatf("vec%0d", i));
    end

    // Back-to-back: next block offered while the digest sits unconsumed.
    exp_ctx.push_back(Iv);
    send_block(blk_abc, 1'b1);
    exp_ctx.push_back(Iv);
    bad = 0;
    begin
      int n = 0;
      while (!digest_valid && n < 3000) begin
        @(negedge clk);
        n++;
      end
    end
    blk_valid = 1'b1; blk_data = blk_empty; blk_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (blk_ready || !digest_valid || digest !== DigAbc || !busy) bad++;
      @(negedge clk);
    end
    check("b2b_hold", 160'(bad), 160'(0));
    check("b2b_first", digest, DigAbc);
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    check("b2b_consumed", 160'(digest_valid), 160'(0));
    check("b2b_ready_after", 160'(blk_ready), 160'(1));
    @(negedge clk);
    blk_valid = 1'b0; blk_data = '0; blk_last = 1'b0;
    check("b2b_accepted", 160'(busy), 160'(1));
    get_digest(DigEmpty, 0, "b2b_second");

    // Reset in WAIT of the first block of a two-block message.
    exp_ctx.push_back(Iv);
    send_block(blk_two0, 1'b0);
    wait_start(1'b1, "mid_rst_start_hi");
    wait_start(1'b0, "mid_rst_start_lo");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 160'(busy), 160'(0));
    check("mid_rst_ready", 160'(blk_ready), 160'(1));
    check("mid_rst_ctx", core_context_in, Iv);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (busy || digest_valid) bad++;
      @(negedge clk);
    end
    check("mid_rst_late_done", 160'(bad), 160'(0));
    msg[0] = blk_abc;
    run_msg(1, DigAbc, 0, "mid_rst_abc");

    // Random messages against the reference fold from the IV.
    for (int r = 0; r < 20; r++) begin
      int nb;
      nb = $urandom_range(3, 1);
      for (int i = 0; i < nb; i++)
        for (int j = 0; j < 16; j++) msg[i][32 * j +: 32] = $urandom;
      run_msg(nb, ref_digest(nb), $urandom_range(3, 0), $sformatf("rand%0d", r));
    end

`ifdef SHA1_CTRL_TIMEOUT_EN
    hang = 1'b1;
    exp_ctx.push_back(Iv);
    send_block(blk_two0, 1'b0);
    wait_start(1'b1, "wd_start_hi");
    wait_start(1'b0, "wd_start_lo");
    repeat (MaxWait - 1) @(negedge clk);
    check("wd_err_before", 160'(err), 160'(0));
    check("wd_busy_before", 160'(busy), 160'(1));
    @(negedge clk);
    check("wd_err", 160'(err), 160'(1));
    check("wd_idle", 160'(busy), 160'(0));
    check("wd_ready", 160'(blk_ready), 160'(1));
    check("wd_no_digest", 160'(digest_valid), 160'(0));
    hang = 1'b0;
    msg[0] = blk_abc;
    run_msg(1, DigAbc, 0, "wd_recover");
    check("wd_err_sticky", 160'(err), 160'(1));
`else
    check("err_tied", 160'(err), 160'(0));
`endif

    repeat (5) @(negedge clk);
    check("ctx_queue_empty", 160'(exp_ctx.size()), 160'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha1_msg_ctrl.md
Name: sha1_msg_ctrl

Overview:
Message-level sequencer for the single-block SHA-1 compression core, `sha1_block`. It accepts a stream of pre-padded 512-bit blocks over a valid/ready handshake and loads the standard initial context on the first block of each message. It drives the core's start/done protocol, chains each block's output context into the next block, and presents the final 160-bit digest on a valid/ready output. It sits between the host-side padding/UART framing logic and `sha1_block`.

Parameters:
- START_CYCLES, 3, number of consecutive cycles `core_start` is held high per block (1..15).
- MAX_WAIT, 127, watchdog limit in cycles for `core_done`; used only with SHA1_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- blk_valid  in  1  `blk_data` is valid.
- blk_ready  out  1  controller can accept a block.
- blk_data  in  512  padded message block, big-endian (word 0 in [511:480]).
- blk_last  in  1  block is the final block of the message; sampled with `blk_data`.
- core_start  out  1  start strobe to `sha1_block`.
- core_block  out  512  registered block to the core.
- core_context_in  out  160  registered chaining context to the core.
- core_done  in  1  core completion flag.
- core_context_out  in  160  core result; already includes the feed-forward addition.
- digest_valid  out  1  `digest` holds the final hash.
- digest_ready  in  1  consumer accepts the digest.
- digest  out  160  {h0,h1,h2,h3,h4}.
- busy  out  1  high in every state except IDLE.
- err  out  1  watchdog error flag (see Optional Feature); tied 0 when the feature is compiled out.

Behaviour:
- Chosen: one clock; reset is synchronous and active-high. Ports are `clk` and `rst`.
- Reset values:
  - state = IDLE; `blk_ready` = 1; `core_start` = 0.
  - `core_block` = 0.
  - `core_context_in` = {67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0}.
  - `digest_valid` = 0; `digest` = 0; `busy` = 0; `err` = 0.
  - `first` flag = 1; `last` flag = 0.
- States: IDLE, START, WAIT, OUT.
- IDLE:
  - `blk_ready` = 1 (combinational from state only).
  - On `blk_valid` && `blk_ready`: latch `blk_data` into `core_block` and `blk_last` into `last`.
  - If `first`=1, load `core_context_in` with the initial constants.
  - Clear the start counter and go to START.
- START:
  - `core_start` = 1 for exactly START_CYCLES cycles, counted from the first START cycle; then go to WAIT.
  - `core_done` is ignored in START.
- WAIT:
  - `core_start` = 0. The first WAIT cycle ignores `core_done` (the core clears done while started).
  - From the second WAIT cycle on, `core_done`=1 means the block is complete:
    - `core_context_in` <= `core_context_out`.
    - If `last`: `digest` <= `core_context_out`, `digest_valid` <= 1, `first` <= 1, go to OUT.
    - Otherwise: `first` <= 0, go to IDLE.
- OUT:
  - `digest_valid` holds and `digest` is stable until `digest_ready`.
  - On `digest_valid` && `digest_ready`: `digest_valid` <= 0, go to IDLE.
  - `blk_ready` = 0 in OUT; a new message cannot start until the digest is consumed.
- Latency per block: 1 accept cycle + START_CYCLES + core compute + 1 capture cycle. The digest is valid the cycle after the last `core_done` is sampled.
- `blk_ready` is low in START/WAIT/OUT. `blk_valid` without `blk_ready` has no effect; the upstream holds data.
- `digest_ready` asserted while `digest_valid`=0 is ignored.
- `rst` mid-message: abandons the block and returns all registers to reset values in the same edge. A `core_done` arriving afterwards is ignored (state IDLE).
- A message of a single block with `blk_last`=1 uses the initial context and emits the digest directly.

Optional Feature:
- Macro: SHA1_CTRL_TIMEOUT_EN.
- When defined:
  - A 7-bit+ counter runs in WAIT. If MAX_WAIT cycles elapse without `core_done`, `err` <= 1 (sticky until `rst`) and state returns to IDLE with `first` <= 1.
  - The partial message is discarded and no digest is emitted.
- When undefined: no counter; WAIT is unbounded; `err` is constant 0.

Decomposition:
- Package `sha1_pkg`:
  - SHA1_H0..SHA1_H4 initial-context constants and their 160-bit concatenation SHA1_IV.
  - Block and digest width constants (512, 160).
  - State enum encoding (IDLE=0, START=1, WAIT=2, OUT=3).
- One natural sub-module: `sha1_ctrl_timer`, holding the START_CYCLES strobe counter plus the optional watchdog counter. The FSM and datapath registers stay in `sha1_msg_ctrl`.

Test Plan:
- Empty message, block {80h, 504'h0}, `blk_last`=1 → `digest` = da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709, `digest_valid` high until `digest_ready`.
- "abc", block {"abc", 80h, 416'h0, 64'd24}, `blk_last`=1 → a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (448 bits), second block `blk_last`=1 → 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1. Check second-block `core_context_in` equals the first-block `core_context_out`.
- Back-to-back messages ("abc", then empty) with `digest_ready` held low 10 cycles → `blk_ready` stays 0 during OUT. Second digest uses the fresh IV and equals da39a3ee….
- Assert `rst` during WAIT of block 1 of the two-block message, then send "abc" → digest a9993e36… (no stale context). `core_start` was high exactly START_CYCLES=3 cycles per block.
- With SHA1_CTRL_TIMEOUT_EN and `core_done` held 0 → `err`=1 after 127 WAIT cycles, state returns to IDLE, `blk_ready`=1, no `digest_valid`.
